// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, DIG_PER_CYC digits per clock, LSD first.
// States: S_IDLE | waiting for start, outputs hold;  S_CALC | rippling digits into r_acc
module bcd_addsub_serial #(
  parameter int DIGITS      = 8,
  parameter int DIG_PER_CYC = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic                carry_in,
  input  logic [4*DIGITS-1:0] arg1,
  input  logic [4*DIGITS-1:0] arg2,
  output logic [4*DIGITS-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                invalid
);

  localparam int W   = 4 * DIGITS;
  localparam int SHW = 4 * DIG_PER_CYC;
  localparam int L   = DIGITS / DIG_PER_CYC;
  localparam int CW  = (L > 1) ? $clog2(L) : 1;

  if (DIGITS % DIG_PER_CYC != 0) begin : g_bad_param
    $error("bcd_addsub_serial: DIG_PER_CYC must divide DIGITS");
  end

  typedef enum logic {S_IDLE, S_CALC} state_t;

  state_t          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_acc;
  logic            r_sub;
  logic            r_carry;
  logic            r_bad;
  logic [CW-1:0]   r_left;

  logic            w_bad_in;
  logic [SHW-1:0]  w_sum;
  logic            w_cout;
  logic [W-1:0]    w_acc_next;

  always_comb begin
    w_bad_in = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (arg1[4*i +: 4] > 4'd9 || arg2[4*i +: 4] > 4'd9) w_bad_in = 1'b1;
    end
  end

  // Subtraction is A + (9's complement of B) with the incoming borrow inverted.
  always_comb begin
    logic [4:0] s;
    logic [3:0] bd;
    logic       c;
    c     = r_carry;
    s     = '0;
    bd    = '0;
    w_sum = '0;
    for (int i = 0; i < DIG_PER_CYC; i++) begin
      bd = r_sub ? (4'd9 - r_b[4*i +: 4]) : r_b[4*i +: 4];
      s  = {1'b0, r_a[4*i +: 4]} + {1'b0, bd} + {4'b0000, c};
      if (s > 5'd9) begin
        w_sum[4*i +: 4] = 4'(s - 5'd10);
        c               = 1'b1;
      end else begin
        w_sum[4*i +: 4] = s[3:0];
        c               = 1'b0;
      end
    end
    w_cout = c;
  end

  // New digits enter at the top so digit 0 lands at the bottom after L shifts.
  assign w_acc_next = (r_acc >> SHW) | (W'(w_sum) << (W - SHW));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_bad    <= 1'b0;
      r_left   <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= arg1;
            r_b     <= arg2;
            r_sub   <= sub;
            r_carry <= sub ? ~carry_in : carry_in;
            r_bad   <= w_bad_in;
            r_left  <= CW'(L - 1);
            r_acc   <= '0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_a     <= r_a >> SHW;
          r_b     <= r_b >> SHW;
          r_carry <= w_cout;
          r_acc   <= w_acc_next;
          if (r_left == '0) begin
            result   <= r_bad ? '0 : w_acc_next;
            overflow <= r_bad ? 1'b0 : (r_sub ? ~w_cout : w_cout);
            invalid  <= r_bad;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_left <= r_left - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Self-checking bench for bcd_addsub_serial: directed table, handshake corners,
// randomized ops against an integer-arithmetic reference, and 2/8 digits-per-cycle variants.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        reset, start, sub, carry_in;
  logic [31:0] arg1, arg2;

  logic [31:0] result1, result2, result8;
  logic        busy1, busy2, busy8, done1, done2, done8;
  logic        ovf1, ovf2, ovf8, inv1, inv2, inv8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(8), .DIG_PER_CYC(1)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .carry_in(carry_in),
    .arg1(arg1), .arg2(arg2), .result(result1), .busy(busy1), .done(done1),
    .overflow(ovf1), .invalid(inv1));

  bcd_addsub_serial #(.DIGITS(8), .DIG_PER_CYC(2)) dut_p2 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .carry_in(carry_in),
    .arg1(arg1), .arg2(arg2), .result(result2), .busy(busy2), .done(done2),
    .overflow(ovf2), .invalid(inv2));

  bcd_addsub_serial #(.DIGITS(8), .DIG_PER_CYC(8)) dut_p8 (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .carry_in(carry_in),
    .arg1(arg1), .arg2(arg2), .result(result8), .busy(busy8), .done(done8),
    .overflow(ovf8), .invalid(inv8));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] res;
    logic        ovf;
    logic        inv;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint bcd2int(input logic [31:0] v);
    longint r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(input longint n);
    logic [31:0] r = '0;
    longint      m = n;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [31:0] v);
    for (int i = 0; i < 8; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: plain integer add/subtract modulo 10^8.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic cin, output logic [31:0] res, output logic ovf,
                       output logic inv);
    longint x, y, r;
    if (has_bad(a) || has_bad(b)) begin
      res = '0; ovf = 1'b0; inv = 1'b1;
      return;
    end
    x = bcd2int(a);
    y = bcd2int(b);
    inv = 1'b0;
    if (!s) begin
      r   = x + y + longint'(cin);
      ovf = (r >= 100000000);
      res = int2bcd(r % 100000000);
    end else begin
      r   = x - y - longint'(cin);
      ovf = (r < 0);
      res = int2bcd(r < 0 ? r + 100000000 : r);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic cin, input logic [31:0] eres,
                        input logic eovf, input logic einv);
    int cyc;
    @(negedge clk);
    arg1 = a; arg2 = b; sub = s; carry_in = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy"}, 64'(busy1), 64'(1));
    wait_done(cyc);
    check({name, " done"}, 64'(done1), 64'(1));
    check({name, " latency"}, 64'(cyc), 64'(8));
    check({name, " result"}, 64'(result1), 64'(eres));
    check({name, " overflow"}, 64'(ovf1), 64'(eovf));
    check({name, " invalid"}, 64'(inv1), 64'(einv));
    check({name, " busy low"}, 64'(busy1), 64'(0));
  endtask

  initial begin
    int          cyc, l1, l2, l8, c;
    logic        saw;
    logic [31:0] ra, rb, eres;
    logic        rs, rc, eovf, einv;

    vecs[0] = '{32'h00000035, 32'h00000078, 1'b0, 1'b0, 32'h00000113, 1'b0, 1'b0};
    vecs[1] = '{32'h99999999, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0};
    vecs[3] = '{32'h00000100, 32'h00000001, 1'b1, 1'b0, 32'h00000099, 1'b0, 1'b0};
    vecs[4] = '{32'h00000001, 32'h00000002, 1'b1, 1'b0, 32'h99999999, 1'b1, 1'b0};
    vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h99999999, 1'b1, 1'b0};
    vecs[6] = '{32'h0000000A, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[7] = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
    vecs[8] = '{32'h23406568, 32'h79000000, 1'b0, 1'b0, 32'h02406568, 1'b1, 1'b0};
    vecs[9] = '{32'h50000000, 32'h49999999, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};

    reset = 1'b1; start = 1'b0; sub = 1'b0; carry_in = 1'b0; arg1 = '0; arg2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset result", 64'(result1), 64'(0));
    check("reset busy", 64'(busy1), 64'(0));
    check("reset done", 64'(done1), 64'(0));
    check("reset overflow", 64'(ovf1), 64'(0));
    check("reset invalid", 64'(inv1), 64'(0));

    // All three widths together: latency 8/4/1
    arg1 = 32'h23406568; arg2 = 32'h79000000; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l1 = -1; l2 = -1; l8 = -1; c = 0;
    while (c < 20 && (l1 < 0 || l2 < 0 || l8 < 0)) begin
      @(negedge clk);
      c++;
      if (done1 && l1 < 0) l1 = c;
      if (done2 && l2 < 0) l2 = c;
      if (done8 && l8 < 0) l8 = c;
    end
    check("p1 latency", 64'(l1), 64'(8));
    check("p2 latency", 64'(l2), 64'(4));
    check("p8 latency", 64'(l8), 64'(1));
    check("p2 result", 64'(result2), 64'(32'h02406568));
    check("p8 result", 64'(result8), 64'(32'h02406568));
    check("p2 overflow", 64'(ovf2), 64'(1));
    check("p8 overflow", 64'(ovf8), 64'(1));

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin,
             vecs[i].res, vecs[i].ovf, vecs[i].inv);

    // Start pulsed while busy is ignored
    @(negedge clk);
    arg1 = 32'h00000035; arg2 = 32'h00000078; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    arg1 = 32'h00000001; arg2 = 32'h00000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("busy-start latency", 64'(cyc), 64'(4));
    check("busy-start result", 64'(result1), 64'(32'h00000113));
    @(negedge clk);
    check("busy-start no requeue", 64'(busy1), 64'(0));

    // Start during the done cycle: back-to-back
    @(negedge clk);
    arg1 = 32'h00000001; arg2 = 32'h00000002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("b2b first result", 64'(result1), 64'(32'h00000003));
    arg1 = 32'h00000005; arg2 = 32'h00000005; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b busy again", 64'(busy1), 64'(1));
    check("b2b held result", 64'(result1), 64'(32'h00000003));
    wait_done(cyc);
    check("b2b second latency", 64'(cyc), 64'(8));
    check("b2b second result", 64'(result1), 64'(32'h00000010));

    // Operand change mid-operation
    @(negedge clk);
    arg1 = 32'h00000035; arg2 = 32'h00000078; sub = 1'b1; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    arg1 = 32'h99999999; arg2 = 32'h00000000; sub = 1'b0; carry_in = 1'b1;
    wait_done(cyc);
    check("argchg result", 64'(result1), 64'(32'h99999957));
    check("argchg overflow", 64'(ovf1), 64'(1));

    // Reset mid-operation
    run_op("pre-reset", 32'h99999999, 32'h00000002, 1'b0, 1'b0, 32'h00000001, 1'b1, 1'b0);
    @(negedge clk);
    arg1 = 32'h00000035; arg2 = 32'h00000078; sub = 1'b0; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset result", 64'(result1), 64'(0));
    check("midreset busy", 64'(busy1), 64'(0));
    check("midreset overflow", 64'(ovf1), 64'(0));
    check("midreset invalid", 64'(inv1), 64'(0));
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done1) saw = 1'b1;
    end
    check("midreset no done", 64'(saw), 64'(0));
    run_op("post-reset", 32'h00000035, 32'h00000078, 1'b0, 1'b0, 32'h00000113, 1'b0, 1'b0);

    // Reset beats start in the same cycle
    @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset-vs-start busy", 64'(busy1), 64'(0));

    for (int n = 0; n < 40; n++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < 8; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) ra[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
        else                           rb[4*$urandom_range(0, 7) +: 4] = 4'($urandom_range(10, 15));
      end
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      model(ra, rb, rs, rc, eres, eovf, einv);
      run_op($sformatf("rand%0d", n), ra, rb, rs, rc, eres, eovf, einv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
